// File: rtl/spi_target_if.sv
// SPI target bus bundle: SPI pins plus the host-side tx/rx handshake, flags and CRC.
// The slave modport is the target's view; master is the host/bench view.
interface spi_target_if;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        clr_flags;
    logic        overrun;
    logic        underrun;
    logic        crc_reset;
    logic        crc_source;
    logic [15:0] crc_out;

    modport slave (
        input  cs_n, sclk, mosi, tx_data, tx_load, rx_ack, clr_flags, crc_reset, crc_source,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun, crc_out
    );

    modport master (
        output cs_n, sclk, mosi, tx_data, tx_load, rx_ack, clr_flags, crc_reset, crc_source,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, underrun, crc_out
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target with oversampled pins, rx byte handshake, single tx holding register.
// Optional CRC16 (x^16+x^12+x^5+1) generator enabled by defining SPI_TARGET_CRC_EN.
module spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_target_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [2:0]             bit_cnt;
    logic                   byte_end;
    logic [6:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic [7:0]             hold;
    logic                   tx_ready;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   overrun;
    logic                   underrun;
    logic                   load_evt, shift_evt, rise_evt, byte_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '1;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // A deselect in the same cycle as an SCLK edge wins over the edge.
    assign rise_evt  = (state == ACTIVE) && !cs_rise && sclk_rise;
    assign byte_done = rise_evt && (bit_cnt == 3'd7);
    assign load_evt  = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && !cs_rise && sclk_fall && byte_end);
    assign shift_evt = (state == ACTIVE) && !cs_rise && sclk_fall && !byte_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            byte_end <= 1'b0;
            rx_shift <= 7'd0;
            tx_shift <= 8'hFF;
            hold     <= 8'h00;
            tx_ready <= 1'b1;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= 3'd0;
                        byte_end <= 1'b0;
                        tx_shift <= 8'hFF;
                    end
                end
                default: state <= IDLE;
            endcase

            // tx_ready=1 means the holding register is empty: send all-ones instead.
            if (load_evt) begin
                tx_shift <= tx_ready ? 8'hFF : hold;
                byte_end <= 1'b0;
            end
            if (shift_evt)
                tx_shift <= {tx_shift[6:0], 1'b1};

            if (rise_evt) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    byte_end <= 1'b1;
            end

            // A transfer out of the hold frees it, so a same-cycle load still lands.
            if (bus.tx_load && (tx_ready || load_evt)) begin
                hold     <= bus.tx_data;
                tx_ready <= 1'b0;
            end else if (load_evt) begin
                tx_ready <= 1'b1;
            end

            if (byte_done) begin
                rx_data  <= {rx_shift, mosi_s};
                rx_valid <= 1'b1;
            end else if (bus.rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (byte_done && rx_valid && !bus.rx_ack)
                overrun <= 1'b1;
            else if (bus.clr_flags)
                overrun <= 1'b0;

            if (load_evt && tx_ready)
                underrun <= 1'b1;
            else if (bus.clr_flags)
                underrun <= 1'b0;
        end
    end

    assign bus.miso     = tx_shift[7];
    assign bus.miso_oe  = (state == ACTIVE);
    assign bus.tx_ready = tx_ready;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.overrun  = overrun;
    assign bus.underrun = underrun;

`ifdef SPI_TARGET_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:12], fb ^ c[11], c[10:5], fb ^ c[4], c[3:0], fb};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= 16'h0000;
        else if (rise_evt)
            crc <= crc16_next(crc, bus.crc_source ? tx_shift[7] : mosi_s);
        else if (bus.crc_reset)
            crc <= 16'h0000;
    end

    assign bus.crc_out = crc;
`else
    logic unused_crc_ctrl;
    assign unused_crc_ctrl = bus.crc_reset ^ bus.crc_source;
    assign bus.crc_out     = 16'h0000;
`endif
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged SPI master at clk/10 with scoreboard queues for MISO and rx bytes.
// Covers reset, table-driven single-byte frames, underrun, overrun, partial frames and CRC.
module tb_spi_target;
    logic clk;
    logic rst;
    spi_target_if bus ();

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [7:0] miso_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        logic       preload;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic       exp_unr;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
    endtask

    task automatic pulse_ack_clr();
        bus.rx_ack    = 1'b1;
        bus.clr_flags = 1'b1;
        tick(1);
        bus.rx_ack    = 1'b0;
        bus.clr_flags = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] m, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = m[i];
            tick(5);
            bus.sclk = 1'b1;
            got[i]   = bus.miso;
            tick(5);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] m, input logic [7:0] exp_miso);
        logic [7:0] got;
        miso_q.push_back(exp_miso);
        rx_q.push_back(m);
        spi_bits(m, 8, got);
        chk("miso_byte", {8'h00, got}, {8'h00, miso_q.pop_front()});
        tick(3);
        chk("rx_valid", {15'd0, bus.rx_valid}, 16'd1);
        chk("rx_data", {8'h00, bus.rx_data}, {8'h00, rx_q.pop_front()});
    endtask

    task automatic cs_on();
        bus.cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_off();
        bus.cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] dummy;
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0};

        rst = 1'b1;
        bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b1;
        bus.tx_data = 8'h00; bus.tx_load = 1'b0; bus.rx_ack = 1'b0;
        bus.clr_flags = 1'b0; bus.crc_reset = 1'b0; bus.crc_source = 1'b0;
        tick(3);
        chk("rst_miso", {15'd0, bus.miso}, 16'd1);
        chk("rst_miso_oe", {15'd0, bus.miso_oe}, 16'd0);
        chk("rst_tx_ready", {15'd0, bus.tx_ready}, 16'd1);
        chk("rst_rx_data", {8'h00, bus.rx_data}, 16'h0000);
        chk("rst_rx_valid", {15'd0, bus.rx_valid}, 16'd0);
        chk("rst_crc", bus.crc_out, 16'h0000);
        rst = 1'b0;
        tick(4);

        // Table-driven single-byte frames
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].preload) begin
                load(vecs[v].tx);
                chk("tx_ready_after_load", {15'd0, bus.tx_ready}, 16'd0);
            end
            cs_on();
            chk("miso_oe_active", {15'd0, bus.miso_oe}, 16'd1);
            chk("tx_ready_at_cs", {15'd0, bus.tx_ready}, 16'd1);
            chk("underrun_at_cs", {15'd0, bus.underrun}, {15'd0, vecs[v].exp_unr});
            xfer(vecs[v].mosi, vecs[v].exp_miso);
            cs_off();
            chk("miso_oe_idle", {15'd0, bus.miso_oe}, 16'd0);
            chk("miso_idle", {15'd0, bus.miso}, 16'd1);
            pulse_ack_clr();
            chk("rx_valid_acked", {15'd0, bus.rx_valid}, 16'd0);
        end

        // Two bytes with nothing loaded: all-ones and underrun, cleared by clr_flags
        cs_on();
        xfer(8'h12, 8'hFF);
        xfer(8'h34, 8'hFF);
        cs_off();
        chk("underrun_set", {15'd0, bus.underrun}, 16'd1);
        bus.clr_flags = 1'b1; tick(1); bus.clr_flags = 1'b0;
        chk("underrun_cleared", {15'd0, bus.underrun}, 16'd0);
        bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;

        // Overrun without ack, then none with an ack in between
        cs_on();
        xfer(8'h11, 8'hFF);
        chk("overrun_first", {15'd0, bus.overrun}, 16'd0);
        xfer(8'h22, 8'hFF);
        cs_off();
        chk("overrun_set", {15'd0, bus.overrun}, 16'd1);
        pulse_ack_clr();
        chk("overrun_cleared", {15'd0, bus.overrun}, 16'd0);
        cs_on();
        xfer(8'h11, 8'hFF);
        bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
        xfer(8'h22, 8'hFF);
        cs_off();
        chk("overrun_acked", {15'd0, bus.overrun}, 16'd0);
        pulse_ack_clr();

        // Partial frame: 5 bits then deselect; hold loaded mid-frame survives
        cs_on();
        load(8'h96);
        spi_bits(8'hE7, 5, dummy);
        cs_off();
        chk("partial_rx_valid", {15'd0, bus.rx_valid}, 16'd0);
        chk("partial_hold_kept", {15'd0, bus.tx_ready}, 16'd0);
        pulse_ack_clr();
        cs_on();
        xfer(8'h81, 8'h96);
        cs_off();
        pulse_ack_clr();

        // Ignored load while full, then a second byte queued mid-frame
        load(8'h12);
        load(8'h34);
        cs_on();
        load(8'h56);
        xfer(8'hA0, 8'h12);
        xfer(8'h0B, 8'h56);
        cs_off();
        pulse_ack_clr();

        // Asynchronous reset in the middle of a byte
        load(8'h3C);
        cs_on();
        spi_bits(8'h00, 4, dummy);
        bus.sclk = 1'b1;
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_miso", {15'd0, bus.miso}, 16'd1);
        chk("mid_rst_miso_oe", {15'd0, bus.miso_oe}, 16'd0);
        chk("mid_rst_tx_ready", {15'd0, bus.tx_ready}, 16'd1);
        chk("mid_rst_rx_valid", {15'd0, bus.rx_valid}, 16'd0);
        chk("mid_rst_flags", {14'd0, bus.overrun, bus.underrun}, 16'd0);
        chk("mid_rst_crc", bus.crc_out, 16'h0000);
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);

`ifdef SPI_TARGET_CRC_EN
        bus.crc_source = 1'b0;
        bus.crc_reset = 1'b1; tick(1); bus.crc_reset = 1'b0;
        chk("crc_reset", bus.crc_out, 16'h0000);
        cs_on();
        for (int b = 0; b < 512; b++)
            spi_bits(8'hFF, 8, dummy);
        cs_off();
        chk("crc_512_ff", bus.crc_out, 16'h7FA1);
`else
        cs_on();
        xfer(8'h5C, 8'hFF);
        cs_off();
        chk("crc_disabled", bus.crc_out, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
